fic_apb_splitter: RTL and testbench
===================================

FIC_APB_SPLITTER -- requirements
Module: fic_apb_splitter

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 Parameters, one per line: name, default, meaning.
- NUM_SLOTS, 4, downstream APB slaves (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- BASE_ADDR, 32'h4000_0000, start of decoded region
- SLOT_SHIFT, 12, log2 of the slot window size in bytes
- TIMEOUT_CYCLES, 255, maximum access-phase wait (0 = no timeout)
REQ-003 Ports, one per line: name, direction, width, meaning.
- MCCC_CLK_BASE, in, 1, clock
- MSS_RESET, in, 1, async active-high reset
- FIC_0_APB_M_PADDR, in, ADDR_WIDTH, upstream address
- FIC_0_APB_M_PSEL / PENABLE / PWRITE, in, 1 each, upstream control
- FIC_0_APB_M_PWDATA, in, DATA_WIDTH, upstream write data
- FIC_0_APB_M_PRDATA, out, DATA_WIDTH, upstream read data
- FIC_0_APB_M_PREADY / PSLVERR, out, 1 each, upstream response
- S_PADDR, out, ADDR_WIDTH, shared downstream address
- S_PWRITE / S_PENABLE, out, 1 each, shared downstream control
- S_PWDATA, out, DATA_WIDTH, shared downstream write data
- S_PSEL, out, NUM_SLOTS, one-hot slot select
- S_PRDATA, in, NUM_SLOTS*DATA_WIDTH, per-slot read data (slot i at bits [i*DW +: DW])
- S_PREADY / S_PSLVERR, in, NUM_SLOTS each, per-slot response
- ERR_COUNT, out, 16, saturating error counter
- LAST_ERR_ADDR, out, ADDR_WIDTH, address of the most recent errored transfer

Function
REQ-004 FSM states SHALL be IDLE, SETUP, ACCESS, DECERR, DONE.
REQ-005 IDLE, FIC_0_APB_M_PSEL=1: latch PADDR, PWRITE and PWDATA.
- Compute slot = (PADDR-BASE_ADDR)>>SLOT_SHIFT.
- In range: go to SETUP. Otherwise: go to DECERR.
REQ-006 SETUP: S_PSEL[slot]=1 and S_PENABLE=0 for exactly one cycle, then ACCESS.
REQ-007 ACCESS: S_PSEL[slot]=1 and S_PENABLE=1; leave on S_PREADY[slot]=1.
- Latch S_PRDATA slot and S_PSLVERR[slot], then go to DONE.
REQ-008 Timeout: counter cleared on entry to ACCESS and incremented each ACCESS cycle.
- When count reaches TIMEOUT_CYCLES with S_PREADY[slot]=0 (TIMEOUT_CYCLES≠0): go to DONE.
- Response on timeout: PSLVERR=1, PRDATA=0.
REQ-009 DECERR: one cycle, no S_PSEL asserted; go to DONE with PSLVERR=1, PRDATA=0.
REQ-010 DONE: FIC_0_APB_M_PREADY=1 for exactly one cycle, with latched PRDATA/PSLVERR; then IDLE.
REQ-011 FIC_0_APB_M_PREADY SHALL be 0 in every state except DONE; PRDATA/PSLVERR SHALL be 0 outside DONE.
REQ-012 Minimum latency, zero-wait slave: PREADY 3 cycles after the cycle PSEL is sampled in IDLE.
REQ-013 S_PADDR, S_PWRITE and S_PWDATA SHALL hold latched values from SETUP through DONE and be 0 in IDLE.
REQ-014 Each DONE with PSLVERR=1 SHALL:
- increment ERR_COUNT, saturating at 16'hFFFF;
- load LAST_ERR_ADDR with the latched address.
REQ-015 Upstream PSEL dropping mid-transfer SHALL be ignored; the transfer completes.
REQ-016 Read data SHALL be for the selected slot only; unselected S_PRDATA, S_PREADY and S_PSLVERR SHALL be ignored.

Reset
REQ-017 On MSS_RESET=1, asynchronously, including mid-transfer:
- FSM to IDLE, all outputs 0;
- ERR_COUNT=0, LAST_ERR_ADDR=0, timeout counter=0.
REQ-018 The first transfer SHALL be accepted in the first cycle after MSS_RESET deasserts.

Structure
REQ-019 Package fic_apb_pkg SHALL hold the FSM state enum, the ERR_COUNT width constant and the default parameter constants.
REQ-020 The timeout counter SHALL be sub-module apb_timeout_ctr, with ports: clear, enable, expired.
REQ-021 Implementation SHALL be 120-400 lines of RTL with no latches.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write to 0x4000_1004, slot 1 PREADY=1 immediately -> S_PSEL=4'b0010; upstream PREADY at cycle 3; PSLVERR=0.
- Read from 0x4000_3000, slot 3 PREADY after 5 waits, PRDATA=0xDEADBEEF -> upstream PRDATA=0xDEADBEEF, PSLVERR=0.
- Access 0x5000_0000 -> no S_PSEL; PSLVERR=1, PRDATA=0; ERR_COUNT=1; LAST_ERR_ADDR=0x5000_0000.
- Slot 2 never ready, TIMEOUT_CYCLES=255 -> PREADY with PSLVERR=1 after 255 ACCESS cycles.
- MSS_RESET pulsed during ACCESS -> S_PSEL=0 and S_PENABLE=0 immediately; next transfer completes normally.
- 65540 decode errors -> ERR_COUNT=16'hFFFF.

Source files
------------

// File: rtl/fic_apb_pkg.sv
`timescale 1ns/1ps
// Shared types and default constants for the FIC APB splitter.
package fic_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR,
    DONE
  } apb_state_e;

  localparam int unsigned ERR_CNT_W = 16;

  localparam int unsigned DEF_NUM_SLOTS      = 4;
  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam logic [31:0] DEF_BASE_ADDR      = 32'h4000_0000;
  localparam int unsigned DEF_SLOT_SHIFT     = 12;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Width needed to index n items; never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
`timescale 1ns/1ps
// Access-phase wait counter: expired fires on the TIMEOUT_CYCLES-th enabled cycle.
module apb_timeout_ctr
  import fic_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count; the count parks at LIMIT so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/fic_apb_splitter.sv
`timescale 1ns/1ps
// One-master to NUM_SLOTS-slave APB splitter with decode errors, timeout and error log.
module fic_apb_splitter
  import fic_apb_pkg::*;
#(
  parameter int unsigned           NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int unsigned           ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(DEF_BASE_ADDR),
  parameter int unsigned           SLOT_SHIFT     = DEF_SLOT_SHIFT,
  parameter int unsigned           TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            MCCC_CLK_BASE,
  input  logic                            MSS_RESET,
  input  logic [ADDR_WIDTH-1:0]           FIC_0_APB_M_PADDR,
  input  logic                            FIC_0_APB_M_PSEL,
  input  logic                            FIC_0_APB_M_PENABLE,
  input  logic                            FIC_0_APB_M_PWRITE,
  input  logic [DATA_WIDTH-1:0]           FIC_0_APB_M_PWDATA,
  output logic [DATA_WIDTH-1:0]           FIC_0_APB_M_PRDATA,
  output logic                            FIC_0_APB_M_PREADY,
  output logic                            FIC_0_APB_M_PSLVERR,
  output logic [ADDR_WIDTH-1:0]           S_PADDR,
  output logic                            S_PWRITE,
  output logic                            S_PENABLE,
  output logic [DATA_WIDTH-1:0]           S_PWDATA,
  output logic [NUM_SLOTS-1:0]            S_PSEL,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] S_PRDATA,
  input  logic [NUM_SLOTS-1:0]            S_PREADY,
  input  logic [NUM_SLOTS-1:0]            S_PSLVERR,
  output logic [ERR_CNT_W-1:0]            ERR_COUNT,
  output logic [ADDR_WIDTH-1:0]           LAST_ERR_ADDR
);

  localparam int unsigned SLOT_W = clog2_min1(NUM_SLOTS);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] last_err_q, last_err_d;

  logic [ADDR_WIDTH-1:0] offset, slot_wide;
  logic                  in_range;
  logic [NUM_SLOTS-1:0]  slot_onehot;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  tmo_clear, tmo_en, tmo_expired;

  // The access phase is tracked internally, so upstream PENABLE carries nothing we need.
  logic unused_penable;
  assign unused_penable = FIC_0_APB_M_PENABLE;

  // Address decode; addresses below BASE_ADDR wrap high and are rejected explicitly.
  assign offset    = FIC_0_APB_M_PADDR - BASE_ADDR;
  assign slot_wide = offset >> SLOT_SHIFT;
  assign in_range  = (FIC_0_APB_M_PADDR >= BASE_ADDR) && (slot_wide < ADDR_WIDTH'(NUM_SLOTS));

  // Only the latched slot's response is observed.
  assign slot_onehot = NUM_SLOTS'(1) << slot_q;
  assign sel_ready   = S_PREADY[slot_q];
  assign sel_err     = S_PSLVERR[slot_q];
  assign sel_rdata   = S_PRDATA[slot_q*DATA_WIDTH +: DATA_WIDTH];

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (MCCC_CLK_BASE),
    .rst    (MSS_RESET),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  // FSM state register.
  always_ff @(posedge MCCC_CLK_BASE or posedge MSS_RESET) begin
    if (MSS_RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; upstream PSEL is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (FIC_0_APB_M_PSEL) state_d = in_range ? SETUP : DECERR;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || tmo_expired) state_d = DONE;
      DECERR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and latched transfer registers.
  always_comb begin
    FIC_0_APB_M_PREADY  = 1'b0;
    FIC_0_APB_M_PRDATA  = '0;
    FIC_0_APB_M_PSLVERR = 1'b0;
    S_PADDR             = '0;
    S_PWRITE            = 1'b0;
    S_PWDATA            = '0;
    S_PENABLE           = 1'b0;
    S_PSEL              = '0;
    tmo_clear           = 1'b0;
    tmo_en              = 1'b0;
    if (state_q != IDLE) begin
      S_PADDR  = addr_q;
      S_PWRITE = write_q;
      S_PWDATA = wdata_q;
    end
    unique case (state_q)
      SETUP: begin
        S_PSEL    = slot_onehot;
        tmo_clear = 1'b1;
      end
      ACCESS: begin
        S_PSEL    = slot_onehot;
        S_PENABLE = 1'b1;
        tmo_en    = 1'b1;
      end
      DONE: begin
        FIC_0_APB_M_PREADY  = 1'b1;
        FIC_0_APB_M_PRDATA  = rdata_q;
        FIC_0_APB_M_PSLVERR = err_q;
      end
      default: ;
    endcase
  end

  // Transfer capture, response capture and error logging.
  always_comb begin
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    slot_d     = slot_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    last_err_d = last_err_q;
    unique case (state_q)
      IDLE: begin
        if (FIC_0_APB_M_PSEL) begin
          addr_d  = FIC_0_APB_M_PADDR;
          write_d = FIC_0_APB_M_PWRITE;
          wdata_d = FIC_0_APB_M_PWDATA;
          slot_d  = SLOT_W'(slot_wide);
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = sel_err;
        end else if (tmo_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      DECERR: begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
      DONE: begin
        if (err_q) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          last_err_d = addr_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge MCCC_CLK_BASE or posedge MSS_RESET) begin
    if (MSS_RESET) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      slot_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      last_err_q <= '0;
    end else begin
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      slot_q     <= slot_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      last_err_q <= last_err_d;
    end
  end

  assign ERR_COUNT     = err_cnt_q;
  assign LAST_ERR_ADDR = last_err_q;

endmodule

// File: tb/tb_fic_apb_splitter.sv
`timescale 1ns/1ps
// Scoreboard bench for fic_apb_splitter with a configurable per-slot APB slave model.
module tb_fic_apb_splitter;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  paddr = '0;
  logic           psel = 1'b0;
  logic           penable = 1'b0;
  logic           pwrite = 1'b0;
  logic [DW-1:0]  pwdata = '0;
  logic [DW-1:0]  prdata;
  logic           pready;
  logic           pslverr;
  logic [AW-1:0]  s_paddr;
  logic           s_pwrite;
  logic           s_penable;
  logic [DW-1:0]  s_pwdata;
  logic [NS-1:0]  s_psel;
  logic [NS*DW-1:0] s_prdata = '0;
  logic [NS-1:0]  s_pready = '1;
  logic [NS-1:0]  s_pslverr = '1;
  logic [15:0]    err_count;
  logic [AW-1:0]  last_err_addr;

  fic_apb_splitter dut (
    .MCCC_CLK_BASE      (clk),
    .MSS_RESET          (rst),
    .FIC_0_APB_M_PADDR  (paddr),
    .FIC_0_APB_M_PSEL   (psel),
    .FIC_0_APB_M_PENABLE(penable),
    .FIC_0_APB_M_PWRITE (pwrite),
    .FIC_0_APB_M_PWDATA (pwdata),
    .FIC_0_APB_M_PRDATA (prdata),
    .FIC_0_APB_M_PREADY (pready),
    .FIC_0_APB_M_PSLVERR(pslverr),
    .S_PADDR            (s_paddr),
    .S_PWRITE           (s_pwrite),
    .S_PENABLE          (s_penable),
    .S_PWDATA           (s_pwdata),
    .S_PSEL             (s_psel),
    .S_PRDATA           (s_prdata),
    .S_PREADY           (s_pready),
    .S_PSLVERR          (s_pslverr),
    .ERR_COUNT          (err_count),
    .LAST_ERR_ADDR      (last_err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Slave model: per-slot wait count, error flag and read data; unselected slots drive noise.
  logic [31:0] rd_data [NS];
  int          wait_cfg [NS];
  logic        slv_err [NS];
  int          acc_cnt = 0;

  always @(negedge clk) begin
    for (int i = 0; i < int'(NS); i++) begin
      if (s_psel[i]) begin
        s_pready[i]  = s_penable && (acc_cnt == wait_cfg[i]);
        s_pslverr[i] = slv_err[i];
        s_prdata[i*DW +: DW] = s_pwrite ? 32'h0 : rd_data[i];
      end else begin
        s_pready[i]  = 1'b1;
        s_pslverr[i] = 1'b1;
        s_prdata[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
      end
    end
    acc_cnt = (s_penable && (s_psel != '0)) ? acc_cnt + 1 : 0;
  end

  // Monitor: every upstream completion is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && pready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pready", 64'(1), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("prdata@%h", mon_e.addr), 64'(prdata), 64'(mon_e.rdata));
        chk($sformatf("pslverr@%h", mon_e.addr), 64'(pslverr), 64'(mon_e.err));
        chk($sformatf("latency@%h", mon_e.addr), 64'(cyc - mon_e.start), 64'(mon_e.lat));
      end
    end
  end

  // One upstream transfer, started in an IDLE cycle right after a negedge.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input logic [3:0] exp_sel, input int exp_lat, input logic drop_sel);
    exp_t e;
    logic got;
    e.addr  = addr;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.start = cyc;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wd;
    psel    = 1'b1;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    @(negedge clk);
    chk("setup_psel", 64'(s_psel), 64'(exp_sel));
    chk("setup_penable", 64'(s_penable), 64'(0));
    if (exp_sel != 4'b0000) begin
      chk("s_paddr", 64'(s_paddr), 64'(addr));
      chk("s_pwrite", 64'(s_pwrite), 64'(wr));
      chk("s_pwdata", 64'(s_pwdata), 64'(wd));
    end
    if (drop_sel) begin
      psel    = 1'b0;
      penable = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0 && exp_sel != 4'b0000) begin
        chk("access_psel", 64'(s_psel), 64'(exp_sel));
        chk("access_penable", 64'(s_penable), 64'(1));
      end
      if (pready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("pready_wait_expired", 64'(0), 64'(1));
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_log(input logic [15:0] cnt, input logic [31:0] addr);
    chk("err_count", 64'(err_count), 64'(cnt));
    chk("last_err_addr", 64'(last_err_addr), 64'(addr));
  endtask

  initial begin
    for (int i = 0; i < int'(NS); i++) begin
      rd_data[i]  = 32'h1111_0000 + 32'(i);
      wait_cfg[i] = 0;
      slv_err[i]  = 1'b0;
    end
    rd_data[0] = 32'h0000_A5A5;
    rd_data[3] = 32'hDEAD_BEEF;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pready", 64'(pready), 64'(0));
    chk("rst_prdata", 64'(prdata), 64'(0));
    chk("rst_pslverr", 64'(pslverr), 64'(0));
    chk("rst_s_psel", 64'(s_psel), 64'(0));
    chk("rst_s_penable", 64'(s_penable), 64'(0));
    chk("rst_s_paddr", 64'(s_paddr), 64'(0));
    chk_log(16'h0000, 32'h0);

    // First transfer issued in the very cycle reset drops.
    rst = 1'b0;
    xfer(32'h4000_1004, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 4'b0010, 3, 1'b0);
    chk_log(16'h0000, 32'h0);

    wait_cfg[3] = 5;
    xfer(32'h4000_3000, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1000, 8, 1'b0);

    xfer(32'h5000_0000, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 2, 1'b0);
    chk_log(16'h0001, 32'h5000_0000);

    wait_cfg[0] = 1;
    slv_err[0]  = 1'b1;
    xfer(32'h4000_0010, 1'b0, 32'h0, 32'h0000_A5A5, 1'b1, 4'b0001, 4, 1'b0);
    chk_log(16'h0002, 32'h4000_0010);

    // Last word of the top slot, with upstream PSEL dropped after setup.
    wait_cfg[3] = 0;
    xfer(32'h4000_3FFC, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1000, 3, 1'b1);
    chk_log(16'h0002, 32'h4000_0010);

    xfer(32'h4000_4000, 1'b1, 32'h5555_AAAA, 32'h0, 1'b1, 4'b0000, 2, 1'b0);
    chk_log(16'h0003, 32'h4000_4000);
    xfer(32'h3FFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 2, 1'b0);
    chk_log(16'h0004, 32'h3FFF_FFFC);

    // Slot 2 never answers: timeout after 255 access cycles.
    wait_cfg[2] = 1000000;
    xfer(32'h4000_2008, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0100, 257, 1'b0);
    chk_log(16'h0005, 32'h4000_2008);
    chk("idle_s_paddr", 64'(s_paddr), 64'(0));
    chk("idle_s_pwdata", 64'(s_pwdata), 64'(0));
    chk("idle_s_psel", 64'(s_psel), 64'(0));
    chk("idle_prdata", 64'(prdata), 64'(0));

    // Reset pulsed while slot 2 is in its access phase.
    paddr   = 32'h4000_2000;
    pwrite  = 1'b0;
    psel    = 1'b1;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_psel", 64'(s_psel), 64'(4'b0100));
    #2 rst = 1'b1;
    #1;
    chk("midrst_s_psel", 64'(s_psel), 64'(0));
    chk("midrst_s_penable", 64'(s_penable), 64'(0));
    chk("midrst_pready", 64'(pready), 64'(0));
    chk_log(16'h0000, 32'h0);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(32'h4000_1000, 1'b1, 32'hCAFE_0001, 32'h0, 1'b0, 4'b0010, 3, 1'b0);
    chk_log(16'h0000, 32'h0);

    // Error counter saturation.
    for (int i = 0; i < 65540; i++) begin
      xfer(32'h8000_0000 + 32'(i * 4), 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000, 2, 1'b0);
    end
    chk_log(16'hFFFF, 32'h8004_000C);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    n_bad = n_bad + 1;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
